data_mem_responder: RTL

Memory-side responder for the pipelined CPU's data-memory port. Accepts one load or store request at a time from the EX/MEM stage over a valid/ready handshake, services it against an internal word-addressed store after a fixed latency, and returns a single-cycle response. Drives a combinational `stall` so the pipeline holds the requesting instruction until its response arrives.

---
 rtl/mem_resp_pkg.sv | 16 +
 rtl/sram_1rw_be.sv | 36 +++
 rtl/data_mem_responder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_resp_pkg;

    localparam int DATA_W             = 32;
    localparam int ADDR_W             = 16;
    localparam int BE_W               = DATA_W / 8;
    localparam int DEFAULT_LATENCY    = 2;
    localparam int DEFAULT_DEPTH_LOG2 = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

endpackage

// File: rtl/sram_1rw_be.sv
// Single-port word store with synchronous read, per-byte write enables and no reset.
module sram_1rw_be
    import mem_resp_pkg::*;
#(
    parameter int AW = DEFAULT_DEPTH_LOG2
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**AW];
    logic [DATA_W-1:0] rdata_q;

    // One access per enabled edge: either merge the enabled bytes or capture a read word.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one request at a time, services it after a fixed latency,
// and returns a one-cycle response while holding the pipeline with a combinational stall.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int LATENCY    = DEFAULT_LATENCY,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall
);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              err_q;
    logic              rdSel_q;
    logic [DATA_W-1:0] sramRdata;
    logic              accept;
    logic              fire;
    logic              inRange;

    // Acceptance is impossible during reset because ready is forced low then.
    assign req_ready  = (state_q == S_IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    assign inRange    = (addr_q >> DEPTH_LOG2) == '0;
    assign fire       = (state_q == S_WAIT) && (cnt_q == 4'd0) && !rst;
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = err_q;
    assign resp_rdata = rdSel_q ? sramRdata : '0;
    assign stall      = req_valid && !resp_valid;

    // Next-state and countdown logic; WAIT lasts LATENCY cycles before the response cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request on the accepting edge so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    // Response flags are set on the WAIT-to-RESP edge and cleared when RESP ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q   <= 1'b0;
            rdSel_q <= 1'b0;
        end else if (fire) begin
            err_q   <= !inRange;
            rdSel_q <= !we_q && inRange;
        end else if (state_q == S_RESP) begin
            err_q   <= 1'b0;
            rdSel_q <= 1'b0;
        end
    end

    sram_1rw_be #(
        .AW(DEPTH_LOG2)
    ) u_sram (
        .clk_i  (clk),
        .en_i   (fire && inRange),
        .we_i   (we_q),
        .be_i   (be_q),
        .addr_i (addr_q[DEPTH_LOG2-1:0]),
        .wdata_i(wdata_q),
        .rdata_o(sramRdata)
    );

endmodule
